// File: rtl/prior_arbiter_8.sv
// Eight-requester arbiter: fixed highest-index priority, or rotating priority when PRIOR_ARB_ROUND_ROBIN_EN is defined.
// Latency: req sampled at an edge is granted after that edge; all outputs are registered.
// Backpressure: the grant is held until done, requester withdrawal, or MAX_HOLD expiry; there is no preemption.
module prior_arbiter_8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [7:0] hold_cnt;
  logic [2:0] win_id;
  logic       rel_wd;
  logic       rel_to;

`ifdef PRIOR_ARB_ROUND_ROBIN_EN
  logic [2:0] ptr;

  // Search ptr-1, ptr-2, ... down to ptr itself; the nearest candidate is assigned last.
  always_comb begin
    win_id = ptr;
    for (int k = 8; k >= 1; k--) begin
      if (req[ptr - 3'(k)]) win_id = ptr - 3'(k);
    end
  end
`else
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) win_id = 3'(i);
    end
  end
`endif

  assign rel_wd = ~req[grant_id];
  assign rel_to = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= 8'h00;
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= 8'd0;
`ifdef PRIOR_ARB_ROUND_ROBIN_EN
      ptr         <= 3'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state       <= S_GRANT;
            grant       <= 8'd1 << win_id;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold_cnt    <= 8'd0;
`ifdef PRIOR_ARB_ROUND_ROBIN_EN
            ptr         <= win_id;
`endif
          end
        end
        S_GRANT: begin
          if (done || rel_wd || rel_to) begin
            state       <= S_IDLE;
            grant       <= 8'h00;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            hold_cnt    <= 8'd0;
            // A normal release on the same edge suppresses the timeout pulse.
            timeout     <= rel_to && !done && !rel_wd;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prior_arbiter_8.sv
// Bench for prior_arbiter_8 (MAX_HOLD=15): table vectors plus hand sequences, expected outputs queued per step.
module tb_prior_arbiter_8;

`ifdef PRIOR_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       vld;
    logic [2:0] id;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] id;
    logic       vld;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[12];

  prior_arbiter_8 #(.MAX_HOLD(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic compare();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got grant=%b, required a queued expectation", grant);
      return;
    end
    e = exp_q.pop_front();
    if ({grant, grant_id, grant_valid, timeout} !== {e.grant, e.id, e.vld, e.to}) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d vld=%b to=%b, required grant=%b id=%0d vld=%b to=%b",
               e.name, grant, grant_id, grant_valid, timeout, e.grant, e.id, e.vld, e.to);
    end
  endtask

  // Drive inputs for one edge, queue the outputs required after it, then check them.
  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic v, input logic [2:0] id, input logic t, input string name);
    exp_t e;
    rst  = r;
    req  = rq;
    done = d;
    e.vld   = v;
    e.id    = v ? id : 3'd0;
    e.grant = v ? (8'd1 << id) : 8'd0;
    e.to    = t;
    e.name  = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    logic [2:0] eid;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    //           rst   req     done  vld   id                  to
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0,               1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0,               1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 3'd7,               1'b0};
    tbl[3]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 3'd0,               1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0,               1'b0};
    tbl[5]  = '{1'b0, 8'h05, 1'b0, 1'b1, 3'd2,               1'b0};
    tbl[6]  = '{1'b0, 8'h05, 1'b0, 1'b1, 3'd2,               1'b0};
    tbl[7]  = '{1'b0, 8'h05, 1'b1, 1'b0, 3'd0,               1'b0};
    tbl[8]  = '{1'b0, 8'h05, 1'b0, 1'b1, RR ? 3'd0 : 3'd2,   1'b0};
    tbl[9]  = '{1'b0, 8'h01, 1'b0, RR,   3'd0,               1'b0};
    tbl[10] = '{1'b0, 8'h01, 1'b0, 1'b1, 3'd0,               1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0,               1'b0};

    for (int i = 0; i < 12; i++)
      step(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].vld, tbl[i].id, tbl[i].to,
           $sformatf("vec%0d", i));

    // Held to timeout: 15 grant cycles, one idle cycle with the pulse, then re-grant.
    for (int i = 0; i < 15; i++)
      step(1'b0, 8'h80, 1'b0, 1'b1, 3'd7, 1'b0, $sformatf("hold_cycle%0d", i + 1));
    step(1'b0, 8'h80, 1'b0, 1'b0, 3'd0, 1'b1, "timeout_pulse");
    step(1'b0, 8'h80, 1'b0, 1'b1, 3'd7, 1'b0, "timeout_regrant");

    // done coincides with the timeout condition on the 15th grant cycle.
    for (int i = 0; i < 14; i++)
      step(1'b0, 8'h80, 1'b0, 1'b1, 3'd7, 1'b0, $sformatf("sim_hold%0d", i + 2));
    step(1'b0, 8'h80, 1'b1, 1'b0, 3'd0, 1'b0, "done_with_timeout");

    // Owner withdraws mid-grant.
    step(1'b0, 8'h80, 1'b0, 1'b1, 3'd7, 1'b0, "wd_grant");
    step(1'b0, 8'h80, 1'b0, 1'b1, 3'd7, 1'b0, "wd_hold");
    step(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "wd_release");
    step(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "wd_idle");

    // All requesting, done pulsed on every grant.
    step(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "rr_reset");
    for (int i = 0; i < 9; i++) begin
      eid = RR ? 3'(7 - (i % 8)) : 3'd7;
      step(1'b0, 8'hFF, 1'b0, 1'b1, eid, 1'b0, $sformatf("rr_grant%0d", i));
      step(1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, $sformatf("rr_release%0d", i));
    end

    // Reset while id 3 owns the grant; rotation restarts from 7.
    step(1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "mid_grant3");
    step(1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "mid_hold3");
    step(1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 1'b0, "mid_reset");
    step(1'b0, 8'hFF, 1'b0, 1'b1, 3'd7, 1'b0, "post_reset_grant");
    step(1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, "post_reset_release");
    step(1'b0, 8'hFF, 1'b0, 1'b1, RR ? 3'd6 : 3'd7, 1'b0, "post_reset_next");
    step(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "final_idle");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
